// File: rtl/stopwatch_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// stopwatch_pkg: state and mode encodings shared by the lap stopwatch. Rev 1.0
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_EXPIRED  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/lap_stopwatch_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lap_stopwatch_if: control pulses, status and lap read port. Rev 1.0
// -----------------------------------------------------------------------------
interface lap_stopwatch_if #(
  parameter int SECONDS_WIDTH = 8
) ();
  logic                     clear;
  logic                     start;
  logic                     continue_pause;
  logic                     lap;
  logic                     count_down;
  logic [SECONDS_WIDTH-1:0] preset;
  logic [SECONDS_WIDTH-1:0] seconds_passed;
  logic                     running;
  logic                     expired;
  logic                     lap_valid;
  logic                     lap_rd;
  logic [SECONDS_WIDTH-1:0] lap_data;
  logic                     lap_overflow;

  modport master (
    output clear, start, continue_pause, lap, count_down, preset, lap_rd,
    input  seconds_passed, running, expired, lap_valid, lap_data, lap_overflow
  );

  modport slave (
    input  clear, start, continue_pause, lap, count_down, preset, lap_rd,
    output seconds_passed, running, expired, lap_valid, lap_data, lap_overflow
  );
endinterface
`default_nettype wire

// File: rtl/lap_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lap_fifo: show-ahead FIFO with a registered head word. Rev 1.0
// -----------------------------------------------------------------------------
module lap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             async_reset,
  input  wire logic             i_clear,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr;
  logic [c_PW-1:0]  r_rd;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_head;
  logic [c_PW-1:0]  w_rd_next;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign w_rd_next = r_rd + c_PW'(1);
  assign o_data    = r_head;

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + c_PW'(1);
      if (w_do_pop)  r_rd <= w_rd_next;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      // The head register is refilled from the next slot, or bypassed from i_data.
      if (w_do_pop) begin
        if (r_count > c_CW'(1)) r_head <= r_mem[w_rd_next];
        else if (w_do_push)     r_head <= i_data;
      end else if (o_empty && w_do_push) begin
        r_head <= i_data;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/lap_stopwatch.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lap_stopwatch: up/down seconds counter with pause and a lap FIFO. Rev 1.0
// -----------------------------------------------------------------------------
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICK_CYCLES   = 50000000,
  parameter int SECONDS_WIDTH = 8,
  parameter int LAP_DEPTH     = 4
) (
  input  wire logic      clk,
  input  wire logic      async_reset,
  lap_stopwatch_if.slave bus
);
  localparam int                   c_TW        = $clog2(TICK_CYCLES);
  localparam logic [c_TW-1:0]      c_TICK_LAST = c_TW'(TICK_CYCLES - 1);
  localparam logic [SECONDS_WIDTH-1:0] c_SEC_ONE = SECONDS_WIDTH'(1);

  state_e                   r_state;
  mode_e                    r_mode;
  logic [c_TW-1:0]          r_tick;
  logic [SECONDS_WIDTH-1:0] r_seconds;
  logic                     r_running;
  logic                     r_expired;
  logic                     r_overflow;

  logic                     w_tick_done;
  logic                     w_zero_down;
  logic                     w_last_down;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [SECONDS_WIDTH-1:0] w_head;

  assign w_tick_done = (r_tick == c_TICK_LAST);
  assign w_zero_down = (r_mode == MODE_DOWN) && (r_seconds == '0);
  assign w_last_down = (r_mode == MODE_DOWN) && w_tick_done && (r_seconds == c_SEC_ONE);
  assign w_push      = bus.lap && ((r_state == ST_COUNTING) || (r_state == ST_PAUSED));
  assign w_pop       = bus.lap_rd;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_UP;
      r_tick     <= '0;
      r_seconds  <= '0;
      r_running  <= 1'b0;
      r_expired  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_state    <= ST_IDLE;
      r_tick     <= '0;
      r_seconds  <= '0;
      r_running  <= 1'b0;
      r_expired  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && w_full && !(w_pop && !w_empty)) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE, ST_EXPIRED: begin
          if (bus.start) begin
            r_state   <= ST_COUNTING;
            r_running <= 1'b1;
            r_expired <= 1'b0;
            r_tick    <= '0;
            r_mode    <= bus.count_down ? MODE_DOWN : MODE_UP;
            r_seconds <= bus.count_down ? bus.preset : '0;
          end
        end
        ST_COUNTING: begin
          // A zero down-count (preset 0) expires without consuming a tick.
          if (w_zero_down) begin
            r_state   <= ST_EXPIRED;
            r_running <= 1'b0;
            r_expired <= 1'b1;
          end else begin
            r_tick <= w_tick_done ? '0 : r_tick + c_TW'(1);
            if (w_tick_done) begin
              r_seconds <= (r_mode == MODE_DOWN) ? r_seconds - c_SEC_ONE
                                                 : r_seconds + c_SEC_ONE;
            end
            if (w_last_down) begin
              r_state   <= ST_EXPIRED;
              r_running <= 1'b0;
              r_expired <= 1'b1;
            end else if (bus.continue_pause) begin
              r_state   <= ST_PAUSED;
              r_running <= 1'b0;
            end
          end
        end
        ST_PAUSED: begin
          if (bus.continue_pause) begin
            r_state   <= ST_COUNTING;
            r_running <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lap_fifo #(
    .WIDTH (SECONDS_WIDTH),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk         (clk),
    .async_reset (async_reset),
    .i_clear     (bus.clear),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (r_seconds),
    .o_data      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign bus.seconds_passed = r_seconds;
  assign bus.running        = r_running;
  assign bus.expired        = r_expired;
  assign bus.lap_valid      = !w_empty;
  assign bus.lap_data       = w_head;
  assign bus.lap_overflow   = r_overflow;
endmodule
`default_nettype wire

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000000: clk cycles per counted second (>=2).
REQ-002 SHALL have parameter SECONDS_WIDTH, default 8: width of the seconds count, preset and lap words.
REQ-003 SHALL have parameter LAP_DEPTH, default 4: lap FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port async_reset  input  1  reset: asynchronous, active-low.
REQ-006 SHALL have port clear  input  1  synchronous clear pulse.
REQ-007 SHALL have port start  input  1  start/restart pulse.
REQ-008 SHALL have port continue_pause  input  1  pause/resume toggle pulse.
REQ-009 SHALL have port lap  input  1  lap capture pulse.
REQ-010 SHALL have port count_down  input  1  mode sampled at start: 0 = up, 1 = down.
REQ-011 SHALL have port preset  input  SECONDS_WIDTH  down-mode start value, sampled at start.
REQ-012 SHALL have port seconds_passed  output  SECONDS_WIDTH  current seconds count (registered).
REQ-013 SHALL have port running  output  1  high in COUNTING.
REQ-014 SHALL have port expired  output  1  high in EXPIRED.
REQ-015 SHALL have port lap_valid  output  1  lap FIFO non-empty.
REQ-016 SHALL have port lap_rd  input  1  pop the lap FIFO head.
REQ-017 SHALL have port lap_data  output  SECONDS_WIDTH  lap FIFO head, valid while lap_valid.
REQ-018 SHALL have port lap_overflow  output  1  sticky flag: a lap was dropped.

Function
REQ-019 SHALL implement states IDLE, COUNTING, PAUSED, EXPIRED; all inputs are synchronous single-cycle pulses.
REQ-020 SHALL give clear priority over every other input: next state IDLE, seconds 0, tick counter 0, FIFO empty, lap_overflow 0.
REQ-021 SHALL handle start in IDLE or EXPIRED: go COUNTING, tick counter 0, latch mode, seconds = 0 (up) or preset (down).
REQ-022 SHALL ignore start in COUNTING and PAUSED.
REQ-023 SHALL toggle COUNTING<->PAUSED on continue_pause; ignore continue_pause in IDLE and EXPIRED.
REQ-024 SHALL count the tick counter 0..TICK_CYCLES-1 in COUNTING only and hold it in PAUSED.
REQ-025 SHALL, at terminal count, wrap the tick counter to 0 and step seconds the same edge, so one second takes exactly TICK_CYCLES cycles.
REQ-026 SHALL wrap seconds from 2^SECONDS_WIDTH-1 to 0 in up mode, with no flag.
REQ-027 SHALL, in down mode, enter EXPIRED on the edge seconds steps 1->0; seconds hold at 0.
REQ-028 SHALL, in down mode with preset = 0, enter EXPIRED one cycle after start without ticking.
REQ-029 SHALL count a tick that coincides with continue_pause in COUNTING; the pause takes effect from the next cycle.
REQ-030 SHALL, on lap in COUNTING or PAUSED, push the seconds value that seconds_passed shows in that same cycle; lap is ignored in IDLE and EXPIRED.
REQ-031 SHALL, on push while full without lap_rd, drop the push and set lap_overflow until clear or reset.
REQ-032 SHALL, on lap_rd with lap_valid, pop the head; lap_rd while empty is ignored.
REQ-033 SHALL, on simultaneous push and pop, do both (full stays full, count unchanged; empty gets one entry, then lap_valid=1 next cycle).
REQ-034 SHALL make lap_data a registered head-of-FIFO value with zero read latency (show-ahead).

Reset
REQ-035 SHALL, on async_reset low, immediately force: state IDLE, tick counter 0, seconds_passed 0, running 0, expired 0, FIFO empty, lap_valid 0, lap_data 0, lap_overflow 0, mode up.
REQ-036 SHALL apply reset mid-count without completing the in-flight second; operation resumes only on a new start.

Structure
REQ-037 SHALL place state encodings and mode constants (MODE_UP, MODE_DOWN) in shared package stopwatch_pkg.
REQ-038 SHALL implement the lap store as sub-module lap_fifo (parameters WIDTH, DEPTH; push/pop/full/empty).
REQ-039 SHALL contain a single clock domain, with no gated or derived clocks.

Verification
REQ-040 SHALL cover, with TICK_CYCLES=4: start (up) -> seconds_passed 1 after 4 cycles and 3 after 12; running=1.
REQ-041 SHALL cover pause: pause at seconds=2 for 20 cycles, then resume -> seconds stays 2 while paused and reaches 3 after the 4 remaining cycles.
REQ-042 SHALL cover down mode: count_down=1, preset=3, start -> EXPIRED/expired=1 after 12 cycles with seconds 0; preset=0 -> expired after 1 cycle.
REQ-043 SHALL cover laps: LAP_DEPTH=4, 5 laps -> lap_overflow=1; 4 pops return the first 4 values in order; lap_valid=0 afterwards.
REQ-044 SHALL cover wrap: SECONDS_WIDTH=3, up mode, 8 seconds elapsed -> seconds_passed returns to 0.
REQ-045 SHALL cover clear with lap and start in the same cycle, and reset mid-count -> all outputs 0, state IDLE, FIFO empty.
